key_dev: RTL and testbench
==========================

KEY_DEV -- requirements
Module: key_dev

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning ABUS/DBUS width.
REQ-002 SHALL have parameter KEY_BITS, default 4, meaning number of raw key inputs (KEY_BITS < BITS).
REQ-003 SHALL have parameter BASE, default 32'hFFFFF080, meaning KDATA address; KCTRL at BASE+4.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning required stable cycles (>= 2).
REQ-005 SHALL have port CLK, input, 1, meaning system clock, all state on rising edge.
REQ-006 SHALL have port RST, input, 1, meaning reset, asynchronous, active-high.
REQ-007 SHALL have port ABUS, input, BITS, meaning processor address bus.
REQ-008 SHALL have port DBUS, inout, BITS, meaning shared data bus.
REQ-009 SHALL have port WE, input, 1, meaning 1 = write cycle, 0 = read cycle.
REQ-010 SHALL have port KEY, input, KEY_BITS, meaning raw asynchronous key levels.
REQ-011 SHALL have port INTR, output, 1, meaning level interrupt request.

Function
REQ-012 SHALL pass KEY through a 2-flop synchronizer before any other use.
REQ-013 SHALL hold KDATA (KEY_BITS) as the debounced key state; it updates only when the synchronized vector has been unchanged for DEBOUNCE_CYCLES consecutive edges and differs from KDATA.
REQ-014 SHALL restart the stability count on any edge where the synchronized vector differs from the previous synchronized sample.
REQ-015 SHALL set KCTRL.Ready (bit 0) on the edge KDATA changes.
REQ-016 SHALL set KCTRL.Overrun (bit 2) on a KDATA change while Ready is already 1; Overrun is sticky.
REQ-017 SHALL clear Ready on the edge closing a read of BASE (ABUS==BASE, WE==0), unless KDATA changes on that same edge, in which case Ready stays 1 and Overrun is unchanged.
REQ-018 SHALL, on write to BASE+4: IE (bit 8) <= DBUS[8]; Overrun cleared if DBUS[2]==0, unchanged if 1; Ready unaffected.
REQ-019 SHALL ignore writes to BASE.
REQ-020 SHALL drive DBUS only when WE==0 and ABUS is BASE or BASE+4, with unused bits zero; otherwise high-Z.
REQ-021 SHALL drive INTR = Ready AND IE combinationally from registers.
REQ-022 SHALL treat multiple bits changing within one stability window as a single KDATA update.

Reset
REQ-023 SHALL on RST clear synchronizer, sample register, counter, KDATA, Ready, Overrun and IE to 0; INTR 0; DBUS high-Z.
REQ-024 SHALL abandon any in-progress debounce count on RST; after release KDATA first reflects held keys after full sync plus debounce latency and sets Ready.

Configuration
REQ-025 SHALL compile debounce logic only when KEY_DEBOUNCE_EN is defined.
REQ-026 SHALL, without KEY_DEBOUNCE_EN, load KDATA directly from the synchronizer output every edge it differs (latency 3 edges from KEY change), Ready/Overrun rules unchanged.

Structure
REQ-027 SHALL place register offsets (KDATA 0, KCTRL 4) and KCTRL bit indices (READY 0, OVERRUN 2, IE 8) in the shared device package.
REQ-028 SHALL implement synchronizer plus stability counter as sub-module key_debounce (in: CLK, RST, raw vector; out: debounced vector, change strobe).

Verification
REQ-029 SHALL verify: DEBOUNCE_CYCLES=4, KEY 0000->0001 held -> KDATA=1, Ready=1 exactly 2+4+1 edges after change; read BASE returns 32'h1.
REQ-030 SHALL verify: KEY toggles every 2 cycles for 20 cycles then returns to 0000 -> KDATA stays 0, Ready stays 0.
REQ-031 SHALL verify: two debounced changes without reading -> KCTRL read = 32'h5; write KCTRL 32'h0 -> reads 32'h1.
REQ-032 SHALL verify: write KCTRL 32'h100 then debounced change -> INTR=1; read BASE -> INTR=0 next edge.
REQ-033 SHALL verify: read of BASE on same edge as a KDATA change -> Ready remains 1, Overrun remains 0.
REQ-034 SHALL verify: RST asserted mid-debounce and on unselected addresses/writes -> all registers 0, DBUS high-Z.

Source files
------------

// File: rtl/key_dev_pkg.sv
// ----------------------------------------------------------------
// key_dev_pkg : register map shared by the key device files
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package key_dev_pkg;

  localparam int unsigned c_kdata_ofs   = 0;
  localparam int unsigned c_kctrl_ofs   = 4;

  localparam int unsigned c_ready_bit   = 0;
  localparam int unsigned c_overrun_bit = 2;
  localparam int unsigned c_ie_bit      = 8;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------
// key_debounce : 2-flop synchronizer plus stability counter (KEY_DEBOUNCE_EN)
// Rev 1.0 ; without KEY_DEBOUNCE_EN the synchronized vector loads directly
// ----------------------------------------------------------------
`default_nettype none

module key_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] i_key,
  output logic [WIDTH-1:0] o_kdata,
  output logic             o_change
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_kdata;

  assign o_kdata = r_kdata;

`ifdef KEY_DEBOUNCE_EN
  localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]   r_sample;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_stable;

  // r_cnt saturates, so a held vector keeps qualifying but only loads on a difference
  assign w_stable = (r_sync2 == r_sample);
  assign o_change = w_stable && (r_cnt == c_cnt_max) && (r_sample != r_kdata);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sample <= '0;
      r_cnt    <= '0;
      r_kdata  <= '0;
    end else begin
      r_sync1  <= i_key;
      r_sync2  <= r_sync1;
      r_sample <= r_sync2;
      if (!w_stable)
        r_cnt <= '0;
      else if (r_cnt != c_cnt_max)
        r_cnt <= r_cnt + 1'b1;
      if (o_change)
        r_kdata <= r_sample;
    end
  end
`else
  assign o_change = (r_sync2 != r_kdata);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_kdata <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      if (o_change)
        r_kdata <= r_sync2;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/key_dev.sv
// ----------------------------------------------------------------
// key_dev : memory-mapped key port (KDATA/KCTRL) with level interrupt
// Rev 1.0 ; debounce compiled in only when KEY_DEBOUNCE_EN is defined
// ----------------------------------------------------------------
`default_nettype none

module key_dev
  import key_dev_pkg::*;
#(
  parameter int              BITS            = 32,
  parameter int              KEY_BITS        = 4,
  parameter logic [BITS-1:0] BASE            = 32'hFFFFF080,
  parameter int              DEBOUNCE_CYCLES = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BITS-1:0]     ABUS,
  inout  wire  [BITS-1:0]     DBUS,
  input  logic                WE,
  input  logic [KEY_BITS-1:0] KEY,
  output logic                INTR
);

  localparam logic [BITS-1:0] c_kdata_addr = BASE + BITS'(c_kdata_ofs);
  localparam logic [BITS-1:0] c_kctrl_addr = BASE + BITS'(c_kctrl_ofs);

  logic [KEY_BITS-1:0] w_kdata;
  logic                w_change;
  logic                r_ready;
  logic                r_overrun;
  logic                r_ie;
  logic                w_sel_kdata;
  logic                w_sel_kctrl;
  logic                w_rd_kdata;
  logic                w_wr_kctrl;
  logic [BITS-1:0]     w_rdata;
  logic                w_unused;

  key_debounce #(
    .WIDTH           (KEY_BITS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK      (CLK),
    .RST      (RST),
    .i_key    (KEY),
    .o_kdata  (w_kdata),
    .o_change (w_change)
  );

  assign w_sel_kdata = (ABUS == c_kdata_addr);
  assign w_sel_kctrl = (ABUS == c_kctrl_addr);
  assign w_rd_kdata  = w_sel_kdata && !WE;
  assign w_wr_kctrl  = w_sel_kctrl && WE;
  assign w_unused    = ^DBUS;

  always_comb begin
    w_rdata = '0;
    if (w_sel_kctrl) begin
      w_rdata[c_ready_bit]   = r_ready;
      w_rdata[c_overrun_bit] = r_overrun;
      w_rdata[c_ie_bit]      = r_ie;
    end else begin
      w_rdata[KEY_BITS-1:0]  = w_kdata;
    end
  end

  assign DBUS = (!WE && (w_sel_kdata || w_sel_kctrl)) ? w_rdata : 'z;
  assign INTR = r_ready && r_ie;

  // A fresh KDATA value beats a same-edge read: Ready stays set and Overrun is left alone
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
      r_ie      <= 1'b0;
    end else begin
      if (w_wr_kctrl) begin
        r_ie <= DBUS[c_ie_bit];
        if (!DBUS[c_overrun_bit])
          r_overrun <= 1'b0;
      end
      if (w_change) begin
        r_ready <= 1'b1;
        if (r_ready && !w_rd_kdata)
          r_overrun <= 1'b1;
      end else if (w_rd_kdata) begin
        r_ready <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_dev.sv
// ----------------------------------------------------------------
// tb_key_dev : directed scoreboard bench for key_dev (DEBOUNCE_CYCLES=4)
// Rev 1.0 ; expected latency follows KEY_DEBOUNCE_EN
// ----------------------------------------------------------------
`default_nettype none

module tb_key_dev;

  localparam int          c_db    = 4;
`ifdef KEY_DEBOUNCE_EN
  localparam int          c_lat   = 2 + c_db + 1;
`else
  localparam int          c_lat   = 3;
`endif
  localparam logic [31:0] c_base  = 32'hFFFFF080;
  localparam logic [31:0] c_kctrl = 32'hFFFFF084;
  localparam logic [31:0] c_idle  = 32'h00001000;
  localparam int          K_BUS   = 0;
  localparam int          K_INTR  = 1;
  localparam int          K_Z     = 2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic [31:0] ABUS;
  logic        WE;
  logic [3:0]  KEY;
  logic        INTR;
  wire  [31:0] DBUS;
  logic        tb_drv;
  logic [31:0] tb_dout;
  logic        done;
  exp_t        q[$];
  int          checks;
  int          errors;

  assign DBUS = tb_drv ? tb_dout : 32'bz;

  key_dev #(
    .BITS            (32),
    .KEY_BITS        (4),
    .BASE            (c_base),
    .DEBOUNCE_CYCLES (c_db)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ABUS (ABUS),
    .DBUS (DBUS),
    .WE   (WE),
    .KEY  (KEY),
    .INTR (INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
    ABUS = a;
    WE   = 1'b0;
    push(K_BUS, v, nm);
    tick();
    ABUS = c_idle;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ABUS    = a;
    WE      = 1'b1;
    tb_dout = d;
    tb_drv  = 1'b1;
    tick();
    tb_drv  = 1'b0;
    WE      = 1'b0;
    ABUS    = c_idle;
  endtask

  task automatic chk_intr(input logic v, input string nm);
    push(K_INTR, {31'b0, v}, nm);
    tick();
  endtask

  task automatic chk_z(input string nm);
    push(K_Z, 32'b0, nm);
    tick();
  endtask

  task automatic rst_checks();
    chk_z("rst_idle_z");
    chk_intr(1'b0, "rst_intr");
    ABUS = c_base;
    WE   = 1'b1;
    chk_z("rst_wr_z");
    WE   = 1'b0;
    ABUS = c_idle;
    rd(c_kctrl, 32'h0, "rst_kctrl");
    rd(c_base,  32'h0, "rst_kdata");
  endtask

  task automatic do_reset();
    #2;
    RST = 1'b1;
    #4;
    tick();
    rst_checks();
    RST = 1'b0;
  endtask

  task automatic lat_check(input string nm);
    for (int i = 0; i <= c_lat; i++)
      rd(c_kctrl, (i >= c_lat) ? 32'h1 : 32'h0, nm);
  endtask

  // stimulus
  initial begin
    RST     = 1'b1;
    ABUS    = c_idle;
    WE      = 1'b0;
    KEY     = 4'h0;
    tb_drv  = 1'b0;
    tb_dout = 32'h0;
    done    = 1'b0;
    tick();
    rst_checks();
    RST = 1'b0;
    tick();

    // single key press, exact latency
    KEY = 4'h1;
    lat_check("lat_ready");
    rd(c_base,  32'h1, "kdata_1");
    rd(c_kctrl, 32'h0, "ready_cleared");
    chk_intr(1'b0, "intr_no_ie");

    // chatter
    KEY = 4'h0;
    do_reset();
`ifdef KEY_DEBOUNCE_EN
    for (int i = 0; i < 10; i++) begin
      KEY = (i % 2 == 0) ? 4'h1 : 4'h0;
      tick();
      tick();
    end
    KEY = 4'h0;
    repeat (c_lat + 4) tick();
    rd(c_kctrl, 32'h0, "chatter_kctrl");
    rd(c_base,  32'h0, "chatter_kdata");
`else
    KEY = 4'h1;
    tick();
    tick();
    KEY = 4'h0;
    repeat (6) tick();
    rd(c_kctrl, 32'h5, "pulse_kctrl");
    rd(c_base,  32'h0, "pulse_kdata");
`endif

    // two changes without a read -> overrun, then clear overrun
    KEY = 4'h0;
    do_reset();
    KEY = 4'h1;
    repeat (c_lat + 2) tick();
    KEY = 4'h3;
    repeat (c_lat + 2) tick();
    rd(c_kctrl, 32'h5, "ovr_kctrl");
    wr(c_kctrl, 32'h0);
    rd(c_kctrl, 32'h1, "ovr_clr");
    rd(c_base,  32'h3, "kdata_3");
    rd(c_kctrl, 32'h0, "kctrl_0");

    // interrupt enable
    wr(c_kctrl, 32'h100);
    chk_intr(1'b0, "intr_ie_only");
    rd(c_kctrl, 32'h100, "ie_set");
    KEY = 4'h0;
    repeat (c_lat + 2) tick();
    chk_intr(1'b1, "intr_on");
    rd(c_kctrl, 32'h101, "ie_ready");
    rd(c_base,  32'h0, "kdata_0");
    chk_intr(1'b0, "intr_off");
    wr(c_base, 32'hF);
    rd(c_base,  32'h0, "wr_base_ignored");
    wr(c_kctrl, 32'h104);
    rd(c_kctrl, 32'h100, "ovr_keep_ready_keep");

    // read on the same edge KDATA changes
    KEY = 4'h0;
    do_reset();
    KEY = 4'h2;
    repeat (c_lat - 1) tick();
    rd(c_base,  32'h0, "race_old_kdata");
    rd(c_kctrl, 32'h1, "race_ready_kept");
    rd(c_base,  32'h2, "race_kdata");
    rd(c_kctrl, 32'h0, "race_cleared");

    // reset in the middle of a debounce, key still held after release
    KEY = 4'h0;
    do_reset();
    KEY = 4'h1;
    tick();
    tick();
    do_reset();
    lat_check("post_rst_lat");
    rd(c_base, 32'h1, "post_rst_kdata");

    done = 1'b1;
  end

  // monitor / scoreboard
  initial begin
    exp_t        e;
    logic        drv;
    logic [31:0] got;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge CLK);
      if (done) begin
        if (q.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL leftover_expectations got %0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      drv = !tb_drv && (DBUS !== 32'bz);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        case (e.kind)
          K_BUS: begin
            got = DBUS;
            if (!drv || got !== e.exp) begin
              errors++;
              $display("FAIL %s got %h required %h", e.name, got, e.exp);
            end
          end
          K_INTR: begin
            got = {31'b0, INTR};
            if (got !== e.exp) begin
              errors++;
              $display("FAIL %s got %h required %h", e.name, got, e.exp);
            end
          end
          default: begin
            got = DBUS;
            if (got !== 32'bz) begin
              errors++;
              $display("FAIL %s got %h required high-Z", e.name, got);
            end
          end
        endcase
      end else if (drv) begin
        checks++;
        errors++;
        $display("FAIL unexpected_drive got %h required high-Z", DBUS);
      end
    end
  end

endmodule

`default_nettype wire
